// File: rtl/rs_latch_sequencer_if.sv
// Request, grant, status and latch-pin bundle for rs_latch_sequencer.
// The master side is the environment (requesters plus the latch itself),
// the slave side is the sequencer that owns every latch input.
interface rs_latch_sequencer_if #(
    parameter int unsigned N_REQ = 4
);
    localparam int unsigned IW = $clog2(N_REQ);

    logic [N_REQ-1:0] req_set;
    logic [N_REQ-1:0] req_rst;
    logic [N_REQ-1:0] grant;
    logic             busy;
    logic             lat_c;
    logic             lat_s;
    logic             lat_r;
    logic             lat_q;
    logic             clr_err;
    logic             err_illegal;
    logic             err_verify;
    logic [IW-1:0]    last_idx;

    modport master (
        output req_set, req_rst, lat_q, clr_err,
        input  grant, busy, lat_c, lat_s, lat_r, err_illegal, err_verify, last_idx
    );

    modport slave (
        input  req_set, req_rst, lat_q, clr_err,
        output grant, busy, lat_c, lat_s, lat_r, err_illegal, err_verify, last_idx
    );
endinterface

// File: rtl/rs_latch_sequencer.sv
// Shares one gated RS latch between N_REQ requesters: round-robin arbitration,
// setup / gate pulse / hold sequencing with S and R never both high, and a
// read-back check of Q. Every output is a register.
module rs_latch_sequencer #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned PULSE_LEN = 2,
    parameter int unsigned HOLD_LEN  = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    rs_latch_sequencer_if.slave bus
);
    localparam int unsigned IW      = $clog2(N_REQ);
    localparam int unsigned CNT_MAX = (PULSE_LEN > HOLD_LEN) ? PULSE_LEN : HOLD_LEN;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_CHECK
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_op;
    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_last;
    logic [N_REQ-1:0] r_grant;
    logic             r_busy;
    logic             r_c;
    logic             r_s;
    logic             r_r;
    logic             r_err_ill;
    logic             r_err_ver;

    state_t           w_state_nx;
    logic [CW-1:0]    w_cnt_nx;
    logic             w_op_nx;
    logic [IW-1:0]    w_idx_nx;
    logic [IW-1:0]    w_ptr_nx;
    logic [IW-1:0]    w_last_nx;
    logic [N_REQ-1:0] w_grant_nx;
    logic             w_busy_nx;
    logic             w_c_nx;
    logic             w_s_nx;
    logic             w_r_nx;
    logic             w_err_ill_nx;
    logic             w_err_ver_nx;
    logic [N_REQ-1:0] w_valid;
    logic [N_REQ-1:0] w_illegal;
    logic             w_hit;
    logic [IW-1:0]    w_hit_idx;
    logic [IW:0]      w_sum;
    logic             w_drive_sr;

    // Next state, arbitration and next values of every registered output
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_op_nx    = r_op;
        w_idx_nx   = r_idx;
        w_ptr_nx   = r_ptr;
        w_last_nx  = r_last;
        w_valid    = bus.req_set ^ bus.req_rst;
        w_illegal  = bus.req_set & bus.req_rst;
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_sum      = '0;

        // Walk ptr, ptr+1, ... with wrap; first valid requester wins
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N_REQ)) begin
                w_sum = w_sum - (IW+1)'(N_REQ);
            end
            if (!w_hit && w_valid[w_sum[IW-1:0]]) begin
                w_hit     = 1'b1;
                w_hit_idx = w_sum[IW-1:0];
            end
        end

        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_state_nx = S_SETUP;
                    w_idx_nx   = w_hit_idx;
                    w_op_nx    = bus.req_set[w_hit_idx];
                end
            end
            S_SETUP: begin
                w_state_nx = S_PULSE;
                w_cnt_nx   = CW'(PULSE_LEN - 1);
            end
            S_PULSE: begin
                if (r_cnt == '0) begin
                    w_state_nx = S_HOLD;
                    w_cnt_nx   = CW'(HOLD_LEN - 1);
                end else begin
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nx = S_CHECK;
                    w_last_nx  = r_idx;
                    w_ptr_nx   = (r_idx == IW'(N_REQ - 1)) ? '0 : r_idx + IW'(1);
                end else begin
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end
            S_CHECK: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // Outputs are Moore-decoded from the next state so they can be registered
        w_drive_sr   = (w_state_nx == S_SETUP) || (w_state_nx == S_PULSE) || (w_state_nx == S_HOLD);
        w_s_nx       = w_drive_sr & w_op_nx;
        w_r_nx       = w_drive_sr & ~w_op_nx;
        w_c_nx       = (w_state_nx == S_PULSE);
        w_busy_nx    = (w_state_nx != S_IDLE);
        w_grant_nx   = (w_state_nx == S_CHECK) ? (N_REQ'(1) << r_idx) : '0;

        // A new error in the clearing cycle wins over clr_err
        w_err_ill_nx = (r_err_ill & ~bus.clr_err) | ((r_state == S_IDLE) && (|w_illegal));
        w_err_ver_nx = (r_err_ver & ~bus.clr_err) | ((r_state == S_CHECK) && (bus.lat_q != r_op));
    end

    // State, counters and registered outputs; reset aborts without a grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_op      <= 1'b0;
            r_idx     <= '0;
            r_ptr     <= '0;
            r_last    <= '0;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_c       <= 1'b0;
            r_s       <= 1'b0;
            r_r       <= 1'b0;
            r_err_ill <= 1'b0;
            r_err_ver <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_op      <= w_op_nx;
            r_idx     <= w_idx_nx;
            r_ptr     <= w_ptr_nx;
            r_last    <= w_last_nx;
            r_grant   <= w_grant_nx;
            r_busy    <= w_busy_nx;
            r_c       <= w_c_nx;
            r_s       <= w_s_nx;
            r_r       <= w_r_nx;
            r_err_ill <= w_err_ill_nx;
            r_err_ver <= w_err_ver_nx;
        end
    end

    assign bus.grant       = r_grant;
    assign bus.busy        = r_busy;
    assign bus.lat_c       = r_c;
    assign bus.lat_s       = r_s;
    assign bus.lat_r       = r_r;
    assign bus.err_illegal = r_err_ill;
    assign bus.err_verify  = r_err_ver;
    assign bus.last_idx    = r_last;
endmodule

// File: doc/rs_latch_sequencer.md
Name: rs_latch_sequencer

Overview:
- Controller that shares one gated RS latch (gate C, inputs S/R, outputs Q/Qn) between N_REQ requesters.
- Serialises set/reset requests with round-robin arbitration and sequences a glitch-safe setup/gate-pulse/hold cycle.
- Guarantees S and R are never both high, then checks the latch Q output against the requested value.
- Sits between the requesting logic and the latch, and owns every latch input.

Parameters:
N_REQ, 4, number of requesters (2..8)
PULSE_LEN, 2, cycles lat_c is held high per operation (>=1)
HOLD_LEN, 1, cycles S/R are held after lat_c falls (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_set  in  N_REQ  per-requester set request (level)
req_rst  in  N_REQ  per-requester reset request (level)
grant  out  N_REQ  one-hot 1-cycle completion pulse to the served requester
busy  out  1  high whenever the state is not IDLE
lat_c  out  1  latch gate
lat_s  out  1  latch S
lat_r  out  1  latch R
lat_q  in  1  latch Q feedback
clr_err  in  1  synchronous clear of both error flags
err_illegal  out  1  sticky: some requester asserted set and rst together
err_verify  out  1  sticky: lat_q did not match the requested value in CHECK
last_idx  out  clog2(N_REQ)  index of the most recently granted requester

Behaviour:
- All outputs are registered. On rst_n low, without waiting for a clock: state=IDLE, grant=0, busy=0, lat_c=lat_s=lat_r=0, err_*=0, last_idx=0, and the round-robin pointer ptr=0.
- Reset during an operation aborts it: no grant is issued, and the latch keeps whatever it held.
- Valid request i: req_set[i] XOR req_rst[i].
- Illegal request i: req_set[i] AND req_rst[i]. While IDLE, any illegal request sets err_illegal, and that requester is never granted while illegal.
- FSM:
  - IDLE: search valid requests from ptr upward with wrap (ptr, ptr+1, ..., N_REQ-1, 0, ...). The first hit j is latched with op = req_set[j]. Next state is SETUP. If there is no hit, stay in IDLE.
  - SETUP (1 cycle): lat_s=op, lat_r=~op, lat_c=0.
  - PULSE (PULSE_LEN cycles): lat_c=1, S/R unchanged.
  - HOLD (HOLD_LEN cycles): lat_c=0, S/R unchanged.
  - CHECK (1 cycle): lat_s=lat_r=0, grant[j]=1, last_idx=j, ptr=(j+1) mod N_REQ. If lat_q != op, err_verify is set. Next state is IDLE.
- Request inputs are sampled only in IDLE. Changes during an operation are ignored until the next IDLE.
- A requester must drop its request in the cycle after grant. If it does not, it is treated as a new request at lowest priority.
- Request-to-lat_s latency: 1 cycle (sampled at edge t, lat_s valid after t+1).
- Operation length: 2+PULSE_LEN+HOLD_LEN cycles, plus 1 IDLE cycle. Back-to-back period is 3+PULSE_LEN+HOLD_LEN (6 at defaults).
- Invariants:
  - lat_s & lat_r == 0 always.
  - lat_c is high only in PULSE.
  - S/R never change in the same cycle lat_c changes.
  - grant is one-hot or zero.
  - busy is high exactly when the state is not IDLE.
- Errors:
  - err_* stay set until clr_err or reset.
  - If clr_err and a new error condition occur in the same cycle, the flag ends up set.
- Duration counters are sized to max(PULSE_LEN, HOLD_LEN) and load at each state entry.

Test Plan:
1. Reset, then req_set=4'b0001 held: lat_s rises 1 cycle later; lat_c is high for exactly 2 cycles; S is held 1 cycle after lat_c falls; grant=4'b0001 in cycle 5; lat_q=1, err_verify=0, busy low after CHECK.
2. req_set=4'b0101 and req_rst=4'b1000 at ptr=0: grants arrive in order 0, 2, 3 at 6-cycle spacing. Requester 3 gets lat_r=1, lat_s=0 and ends with lat_q=0.
3. Starvation check: req0 is re-asserted immediately after every grant while req1 is held. Grants must alternate 0, 1, 0, 1.
4. req_set[2]=req_rst[2]=1 alone: err_illegal=1, no grant, and lat_s/lat_r stay 0. clr_err returns err_illegal to 0.
5. Model lat_q stuck at 0, then request a set: err_verify=1 after CHECK while the grant is still issued. A later reset returns err_verify to 0.
6. Assert rst_n low during PULSE: lat_c, lat_s, lat_r and busy go to 0 immediately, no grant is issued, and after release the FSM is in IDLE with ptr=0. Check the S&R==0 assertion over the whole run.
